// File: rtl/xtal_mon_pkg.sv
// Shared types and helpers for the crystal start-up controller and frequency monitor.
package xtal_mon_pkg;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    STARTUP = 3'd1,
    CHECK   = 3'd2,
    RUN     = 3'd3,
    FAULT   = 3'd4
  } xtal_state_t;

  // Terminal value of a window counter spanning 2^log2 cycles.
  function automatic int unsigned win_term(input int unsigned log2);
    return (32'd1 << log2) - 32'd1;
  endfunction

endpackage

// File: rtl/xtal_edge_sync.sv
// Brings the pad CLK into the clk domain and emits a one-cycle pulse per rising edge.
module xtal_edge_sync (
  input  logic clk,
  input  logic resetn,
  input  logic xtal_clk,
  output logic edge_pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= xtal_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_pulse = s2 & ~s3;

endmodule

// File: rtl/xtal_startup_monitor.sv
// Crystal oscillator start-up sequencer and windowed frequency monitor.
module xtal_startup_monitor
  import xtal_mon_pkg::*;
#(
  parameter int unsigned WIN_LOG2       = 8,
  parameter int unsigned CNT_W          = 9,
  parameter int unsigned MIN_EDGES      = 56,
  parameter int unsigned MAX_EDGES      = 72,
  parameter int unsigned STARTUP_CYCLES = 1024,
  parameter int unsigned GOOD_WINDOWS   = 4,
  parameter int unsigned RETRY_WINDOWS  = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable_req,
  input  logic             xtal_clk,
  output logic             xtal_en,
  output logic             xtal_ok,
  output logic             xtal_fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] edge_count
);

  localparam int unsigned SU_W = (STARTUP_CYCLES > 2) ? $clog2(STARTUP_CYCLES) : 1;
  localparam int unsigned GD_W = $clog2(GOOD_WINDOWS + 1);
  localparam int unsigned BD_W = $clog2(RETRY_WINDOWS + 1);
  localparam logic [WIN_LOG2-1:0] WIN_END = WIN_LOG2'(win_term(WIN_LOG2));
  localparam logic [CNT_W-1:0]    MIN_C   = CNT_W'(MIN_EDGES);
  localparam logic [CNT_W-1:0]    MAX_C   = CNT_W'(MAX_EDGES);

  xtal_state_t       st, nxt;
  logic [SU_W-1:0]   su_cnt;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  closing;
  logic [GD_W-1:0]   good_cnt;
  logic [BD_W-1:0]   bad_cnt;
  logic              edge_pulse;
  logic              win_end;
  logic              in_range;

  xtal_edge_sync u_sync (
    .clk        (clk),
    .resetn     (resetn),
    .xtal_clk   (xtal_clk),
    .edge_pulse (edge_pulse)
  );

  always_comb begin
    win_end  = ((st == CHECK) || (st == RUN)) && (win_cnt == WIN_END);
    // Saturating count that includes any edge seen in the current cycle.
    closing  = (edge_pulse && (edge_cnt != '1)) ? edge_cnt + CNT_W'(1) : edge_cnt;
    in_range = (closing >= MIN_C) && (closing <= MAX_C);
    nxt      = st;
    if (!enable_req) begin
      nxt = OFF;
    end else begin
      case (st)
        OFF:     nxt = STARTUP;
        STARTUP: if (su_cnt == '0) nxt = CHECK;
        CHECK: begin
          if (win_end) begin
            if (in_range) begin
              if (good_cnt == GD_W'(GOOD_WINDOWS - 1)) nxt = RUN;
            end else if (bad_cnt == BD_W'(RETRY_WINDOWS - 1)) begin
              nxt = FAULT;
            end
          end
        end
        RUN:     if (win_end && !in_range) nxt = FAULT;
        FAULT:   nxt = FAULT;
        default: nxt = OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st         <= OFF;
      xtal_en    <= 1'b0;
      xtal_ok    <= 1'b0;
      xtal_fault <= 1'b0;
      edge_count <= '0;
      su_cnt     <= '0;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
    end else begin
      st         <= nxt;
      xtal_en    <= (nxt == STARTUP) || (nxt == CHECK) || (nxt == RUN);
      xtal_ok    <= (nxt == RUN);
      xtal_fault <= (nxt == FAULT);
      if (nxt == OFF) begin
        edge_count <= '0;
        su_cnt     <= '0;
        win_cnt    <= '0;
        edge_cnt   <= '0;
        good_cnt   <= '0;
        bad_cnt    <= '0;
      end else if (st == OFF) begin
        su_cnt <= SU_W'(STARTUP_CYCLES - 1);
      end else if (st == STARTUP) begin
        if (nxt == CHECK) begin
          win_cnt  <= '0;
          edge_cnt <= '0;
          good_cnt <= '0;
          bad_cnt  <= '0;
        end else begin
          su_cnt <= su_cnt - SU_W'(1);
        end
      end else if ((st == CHECK) || (st == RUN)) begin
        win_cnt <= win_cnt + WIN_LOG2'(1);
        if (win_end) begin
          // A final-cycle edge closes this window and also opens the next one.
          edge_count <= closing;
          edge_cnt   <= {{(CNT_W-1){1'b0}}, edge_pulse};
          if (st == CHECK) begin
            if (in_range) begin
              good_cnt <= good_cnt + GD_W'(1);
            end else begin
              good_cnt <= '0;
              bad_cnt  <= bad_cnt + BD_W'(1);
            end
          end
        end else begin
          edge_cnt <= closing;
        end
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_xtal_startup_monitor.sv
// Scoreboard bench: window-level reference model predicts state/outputs at each window end.
module tb_xtal_startup_monitor;

  localparam int S_OFF = 0, S_STARTUP = 1, S_CHECK = 2, S_RUN = 3, S_FAULT = 4;
  localparam int WIN = 256, STARTUP = 1024, MINE = 56, MAXE = 72;
  localparam int NGOOD = 4, NRETRY = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       enable_req = 1'b0;
  logic       xtal_clk = 1'b0;
  logic       xtal_en, xtal_ok, xtal_fault;
  logic [2:0] state;
  logic [8:0] edge_count;

  xtal_startup_monitor #(
    .WIN_LOG2       (8),
    .CNT_W          (9),
    .MIN_EDGES      (56),
    .MAX_EDGES      (72),
    .STARTUP_CYCLES (1024),
    .GOOD_WINDOWS   (4),
    .RETRY_WINDOWS  (16)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable_req (enable_req),
    .xtal_clk   (xtal_clk),
    .xtal_en    (xtal_en),
    .xtal_ok    (xtal_ok),
    .xtal_fault (xtal_fault),
    .state      (state),
    .edge_count (edge_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Crystal model: half-period in clk cycles, 0 means stopped.
  int half = 0;
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #3;
      if (half == 0) begin
        xtal_clk = 1'b0;
        cnt = 0;
      end else begin
        cnt++;
        if (cnt >= half) begin
          xtal_clk = ~xtal_clk;
          cnt = 0;
        end
      end
    end
  end

  typedef struct {
    int    at;
    int    st;
    bit    chk_edge;
    int    nom;
    int    tol;
    string tag;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  int m_st = S_OFF;
  int m_good = 0;
  int m_bad = 0;
  int run_wins = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_near(input string name, input int act, input int nom, input int tol);
    int d;
    tests++;
    d = (act > nom) ? act - nom : nom - act;
    if (d > tol) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d (cycle %0d)", name, act, nom, tol, cyc);
    end
  endtask

  task automatic push(input int at, input int st, input bit chk_edge, input int nom,
                      input int tol, input string tag);
    exp_t e;
    e.at = at; e.st = st; e.chk_edge = chk_edge; e.nom = nom; e.tol = tol; e.tag = tag;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      if (e.at < cyc) begin
        check({e.tag, ".missed"}, cyc, e.at);
      end else begin
        check({e.tag, ".state"}, int'(state), e.st);
        check({e.tag, ".xtal_en"}, int'(xtal_en),
              int'(e.st == S_STARTUP || e.st == S_CHECK || e.st == S_RUN));
        check({e.tag, ".xtal_ok"}, int'(xtal_ok), int'(e.st == S_RUN));
        check({e.tag, ".xtal_fault"}, int'(xtal_fault), int'(e.st == S_FAULT));
        if (e.chk_edge) check_near({e.tag, ".edge_count"}, int'(edge_count), e.nom, e.tol);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic enable_on();
    int c0;
    c0 = cyc;
    enable_req = 1'b1;
    push(c0 + 1, S_STARTUP, 1'b0, 0, 0, "en_rise");
    push(c0 + STARTUP, S_STARTUP, 1'b0, 0, 0, "startup_last");
    push(c0 + STARTUP + 1, S_CHECK, 1'b0, 0, 0, "check_entry");
    m_st = S_CHECK; m_good = 0; m_bad = 0; run_wins = 0;
    step(STARTUP + 1);
  endtask

  task automatic enable_off(input string tag);
    enable_req = 1'b0;
    push(cyc + 1, S_OFF, 1'b0, 0, 0, tag);
    m_st = S_OFF;
    step(2);
  endtask

  // One measurement window with the crystal running at half-period h.
  task automatic window(input int h);
    int nom, tol;
    bit changed, inr;
    changed = (h != half);
    half = h;
    nom = (h == 0) ? 0 : WIN / (2 * h);
    tol = changed ? 3 : ((h == 0) ? 0 : 1);
    inr = (nom >= MINE) && (nom <= MAXE);
    if (m_st == S_CHECK) begin
      if (inr) begin
        m_good++;
        if (m_good == NGOOD) m_st = S_RUN;
      end else begin
        m_good = 0;
        m_bad++;
        if (m_bad == NRETRY) m_st = S_FAULT;
      end
    end else if (m_st == S_RUN) begin
      run_wins++;
      if (!inr) m_st = S_FAULT;
    end
    push(cyc + WIN, m_st, 1'b1, nom, tol, $sformatf("win_h%0d", h));
    step(WIN);
  endtask

  function automatic int pick_h();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return 2;
    return r - 6 + ((r >= 7) ? 0 : 0) == 0 ? 0 : r - 6;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: cycle %0d, expected completion earlier", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    #2 resetn = 1'b0;
    #1;
    check("por.state", int'(state), S_OFF);
    check("por.xtal_en", int'(xtal_en), 0);
    check("por.edge_count", int'(edge_count), 0);
    step(3);
    resetn = 1'b1;
    step(2);

    // Nominal start-up, then asynchronous reset while in RUN.
    half = 2;
    enable_on();
    while (m_st != S_RUN) window(2);
    window(2);
    window(2);
    @(negedge clk);
    #2;
    enable_req = 1'b0;
    resetn = 1'b0;
    #1;
    check("rst_async.state", int'(state), S_OFF);
    check("rst_async.xtal_en", int'(xtal_en), 0);
    check("rst_async.xtal_ok", int'(xtal_ok), 0);
    check("rst_async.xtal_fault", int'(xtal_fault), 0);
    check("rst_async.edge_count", int'(edge_count), 0);
    step(3);
    resetn = 1'b1;
    m_st = S_OFF;
    push(cyc + 1, S_OFF, 1'b1, 0, 0, "post_rst");
    push(cyc + 6, S_OFF, 1'b1, 0, 0, "post_rst_hold");
    step(8);

    // Loss of oscillation while in RUN.
    enable_on();
    while (m_st != S_RUN) window(2);
    window(0);
    enable_off("off_after_loss");

    // Dead crystal: exhaust the retry budget.
    half = 0;
    enable_on();
    while (m_st == S_CHECK) window(0);
    enable_off("off_after_dead");

    // Over-frequency for three windows, then recovery.
    half = 1;
    enable_on();
    repeat (3) window(1);
    while (m_st == S_CHECK) window(2);
    window(2);
    enable_off("off_after_recover");

    // Abort in STARTUP, full restart, abort mid-CHECK, restart to RUN.
    half = 2;
    enable_req = 1'b1;
    push(cyc + 1, S_STARTUP, 1'b0, 0, 0, "abort_su_rise");
    k = $urandom_range(2, 1000);
    step(k);
    enable_off("abort_startup");
    enable_on();
    window(2);
    window(2);
    step($urandom_range(1, 200));
    enable_off("abort_check");
    enable_on();
    while (m_st != S_RUN) window(2);
    enable_off("off_after_rerun");

    // Randomised crystal behaviour per window.
    for (int s = 0; s < 4; s++) begin
      half = $urandom_range(0, 4);
      enable_on();
      for (int w = 0; w < 24 && m_st != S_FAULT && run_wins < 3; w++) window(pick_h());
      enable_off($sformatf("off_rand%0d", s));
    end

    step(4);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
